payload_char_feeder: RTL and testbench
======================================

# payload_char_feeder

Feeds packet payloads to the regex match engines: it accepts payload words from the packet datapath and replays them one byte per cycle. For each byte it drives the engine-side character bus: the byte value, a 256-line one-hot character decode, the per-byte enable `en`, and the start-of-data clear `sod`. At the end of each packet it raises `eop`, marking the cycle in which downstream logic samples the engines' sticky match outputs. It sits between the payload extraction stage and the bank of generated `engine_*` instances.

## Interface
- `DATA_W`, 64: input word width in bits; multiple of 8, 8..256.
- `KEEP_W`, DATA_W/8: byte-lane count (derived; do not override).
- `clk`  in  1  sole clock; all state is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_data`  in  DATA_W  payload word; lane 0 = bits [7:0] = first byte.
- `s_keep`  in  KEEP_W  valid lanes; contiguous from lane 0.
- `s_last`  in  1  word is the last of its packet.
- `s_valid`  in  1  word offered.
- `s_ready`  out  1  word accepted when `s_valid & s_ready`.
- `pause`  in  1  holds byte replay; no `en` while high.
- `char`  out  8  current byte; meaningful only when `en` = 1.
- `char_hot`  out  256  `char_hot[char]` = 1, all other lines 0; forced all-zero when `en` = 0.
- `en`  out  1  one engine step; exactly one per payload byte.
- `sod`  out  1  one-cycle engine clear, issued before a packet's first byte.
- `eop`  out  1  one-cycle pulse; engine outputs are valid for this packet.

## Operation
- Reset values (`rst_n` = 0, asynchronous): `s_ready`=0, `en`=0, `sod`=0, `eop`=0, `char`=0, `char_hot`=0, state=IDLE, buffer empty.
- Holding register: one word plus keep and last. Byte pointer `idx` ranges 0..KEEP_W-1.
- `nbytes` = the number of ones in `s_keep`. A non-contiguous keep is a protocol error: only the lanes below the first zero are replayed.
- **IDLE**
  - `s_ready` = 1.
  - On accept, capture the word, set `idx` = 0, go to SOD.
- **SOD**
  - `sod` = 1 for one cycle; `en` = 0.
  - Next state is STREAM if `nbytes` > 0, otherwise EOP.
- **STREAM**
  - If `pause` = 0, emit lane `idx`: `en` = 1 and `char` = `s_data[8*idx+7:8*idx]`, then increment `idx`.
  - On the final kept lane:
    - if `last` = 1, go to EOP;
    - if `last` = 0 and the next word is accepted in the same cycle, reload it with `idx` = 0 and stay in STREAM;
    - if `last` = 0 and no word is available, go to WAIT.
  - `s_ready` = 1 only in the cycle the final kept lane is emitted and `last` = 0.
  - If `pause` = 1, all state is held and `en` = 0.
- **WAIT**
  - `s_ready` = 1.
  - On accept, go to STREAM; if the accepted word has `nbytes` = 0 and `s_last` = 1, go to EOP.
  - A word with `nbytes` = 0 and `s_last` = 0 is consumed and discarded.
- **EOP**
  - `eop` = 1 for one cycle, `s_ready` = 0, then go to IDLE.
  - `pause` does not delay EOP.
- `sod`, `en` and `eop` are mutually exclusive in every cycle.
- `char_hot` is a full 256-way decode of `char`, registered together with `char` and `en`.

## Timing
- All outputs are registered.
- Word accepted in IDLE at edge T:
  - `sod` is high in cycle T+1;
  - the first `en` is in cycle T+2;
  - with no pause and back-to-back words, one byte is emitted per cycle.
- Last byte emitted in cycle N: `eop` in cycle N+1. The engine's sticky `out` for that packet is valid during N+1, because the engine registers on the edge ending cycle N.
- Next packet: accepted at the earliest at edge N+2 (IDLE), so its `sod` is in cycle N+3. Packets never overlap.
- Throughput: 1 byte/cycle sustained. The per-packet overhead is 3 cycles (SOD, EOP, IDLE accept).
- Reset asserted mid-packet: outputs clear immediately and the partial packet is dropped, with no `eop`. After release, the block restarts in IDLE.

## Test plan
- Single-word packet, DATA_W=64: "`.php?w=1`" (8 bytes), keep=0xFF, last=1 -> `sod` at T+1; `en` T+2..T+9 with `char` 0x2E,0x70,0x68,0x70,0x3F,0x77,0x3D,0x31; `char_hot[0x2E]`=1 at T+2; `eop` at T+10; `s_ready` high again at T+11.
- Two-word packet, second word keep=0x07, with `s_valid` held continuously -> 11 consecutive `en` cycles and no gap between words.
- `pause` asserted for 3 cycles mid-word -> `en` low for exactly those 3 cycles; byte order and count unchanged; `char_hot` all-zero while paused.
- Zero-length packet: keep=0x00, last=1 -> `sod`, then `eop` on the next cycle, no `en`.
- A 9-byte packet where the second word is delayed 4 cycles -> state WAIT, `en` low, `s_ready` high; the byte stream resumes the cycle after the accept.
- `rst_n` pulsed low during byte 3 of 8 -> `en`/`sod`/`eop` go to 0 asynchronously with no `eop`; the following packet starts with `sod` normally.

Source files
------------

// File: rtl/payload_char_feeder.sv
// payload_char_feeder
//   Replays packet payload words one byte per cycle onto the character bus
//   shared by the regex match engines.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     s_data/s_keep/s_last  payload word, contiguous byte-lane keep, last word
//     s_valid/s_ready       word handshake (accept on s_valid & s_ready)
//     pause                 holds byte replay (no en while held)
//     char/char_hot         current byte and its 256-line one-hot decode
//     en                    one engine step per payload byte
//     sod                   engine clear ahead of a packet's first byte
//     eop                   packet done; engine outputs valid this cycle
//
//   Every output is a register. The next-cycle values are worked out in one
//   combinational block and loaded together, so sod/en/eop can never overlap.

// One 16-line slice of the character decode; the upper nibble selects the
// slice, the lower nibble the line within it.
module char_hot_slice #(
  parameter logic [3:0] HI = 4'd0
) (
  input  logic [7:0]  char_val,
  input  logic        en,
  output logic [15:0] hot
);
  always_comb begin
    hot = '0;
    if (en && (char_val[7:4] == HI)) hot = 16'b1 << char_val[3:0];
  end
endmodule

module payload_char_feeder #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic [KEEP_W-1:0] s_keep,
  input  logic              s_last,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              pause,
  output logic [7:0]        char,
  output logic [255:0]      char_hot,
  output logic              en,
  output logic              sod,
  output logic              eop
);

  localparam int IDX_W = (KEEP_W > 1) ? $clog2(KEEP_W) : 1;
  localparam int NB_W  = $clog2(KEEP_W + 1);

  // ST_FIN: last byte is on the bus, eop follows next cycle.
  // ST_WAIT: also covers the cycle the final lane of a non-last word is on
  // the bus, which is exactly when s_ready must be high for a gapless reload.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SOD    = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_FIN    = 3'd4;
  localparam logic [2:0] ST_EOP    = 3'd5;

  // Lanes below the first zero of keep; anything above a hole is ignored.
  function automatic logic [NB_W-1:0] run_len(input logic [KEEP_W-1:0] k);
    logic            stop;
    logic [NB_W-1:0] n;
    stop = 1'b0;
    n    = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (!stop) begin
        if (k[i]) n = n + NB_W'(1);
        else      stop = 1'b1;
      end
    end
    return n;
  endfunction

  // Holding register
  logic [KEEP_W-1:0][7:0] buf_data, buf_data_d;
  logic [NB_W-1:0]        buf_nb, buf_nb_d;
  logic                   buf_last, buf_last_d;
  logic [IDX_W-1:0]       idx, idx_d;
  logic [2:0]             st, st_d;

  logic                   s_ready_d, en_d, sod_d, eop_d;
  logic [7:0]             char_d;
  logic [15:0][15:0]      hot_d;

  logic [KEEP_W-1:0][7:0] in_lanes;
  logic [NB_W-1:0]        in_nb;
  logic                   acc;

  // Byte-step operand: either the held word or the word arriving this cycle
  logic                   step_go, use_in;
  logic [KEEP_W-1:0][7:0] cur_lanes;
  logic [NB_W-1:0]        cur_nb;
  logic                   cur_last;
  logic [IDX_W-1:0]       cur_idx;

  assign in_lanes = s_data;
  assign in_nb    = run_len(s_keep);
  assign acc      = s_valid & s_ready;

  always_comb begin
    st_d       = st;
    buf_data_d = buf_data;
    buf_nb_d   = buf_nb;
    buf_last_d = buf_last;
    idx_d      = idx;
    s_ready_d  = 1'b0;
    en_d       = 1'b0;
    sod_d      = 1'b0;
    eop_d      = 1'b0;
    char_d     = char;
    step_go    = 1'b0;
    use_in     = 1'b0;

    case (st)
      ST_IDLE: begin
        if (acc) begin
          buf_data_d = in_lanes;
          buf_nb_d   = in_nb;
          buf_last_d = s_last;
          idx_d      = '0;
          sod_d      = 1'b1;
          st_d       = ST_SOD;
        end else begin
          s_ready_d  = 1'b1;
        end
      end
      ST_SOD: begin
        if (buf_nb == '0) begin
          eop_d = 1'b1;
          st_d  = ST_EOP;
        end else begin
          step_go = 1'b1;
        end
      end
      ST_STREAM: step_go = 1'b1;
      ST_WAIT: begin
        if (acc) begin
          buf_data_d = in_lanes;
          buf_nb_d   = in_nb;
          buf_last_d = s_last;
          if (in_nb != '0) begin
            step_go = 1'b1;
            use_in  = 1'b1;
          end else if (s_last) begin
            eop_d = 1'b1;
            st_d  = ST_EOP;
          end else begin
            // empty non-last word: swallow it and keep waiting
            s_ready_d = 1'b1;
          end
        end else begin
          s_ready_d = 1'b1;
        end
      end
      ST_FIN: begin
        // pause is deliberately ignored here
        eop_d = 1'b1;
        st_d  = ST_EOP;
      end
      ST_EOP: begin
        s_ready_d = 1'b1;
        st_d      = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase

    cur_lanes = use_in ? in_lanes : buf_data;
    cur_nb    = use_in ? in_nb    : buf_nb;
    cur_last  = use_in ? s_last   : buf_last;
    cur_idx   = use_in ? '0       : idx;

    if (step_go) begin
      if (pause) begin
        idx_d = cur_idx;
        st_d  = ST_STREAM;
      end else begin
        en_d   = 1'b1;
        char_d = cur_lanes[cur_idx];
        if (NB_W'(cur_idx) + NB_W'(1) == cur_nb) begin
          if (cur_last) begin
            st_d = ST_FIN;
          end else begin
            s_ready_d = 1'b1;
            st_d      = ST_WAIT;
          end
        end else begin
          idx_d = cur_idx + IDX_W'(1);
          st_d  = ST_STREAM;
        end
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_hot
    char_hot_slice #(.HI(4'(g))) u_slice (
      .char_val (char_d),
      .en       (en_d),
      .hot      (hot_d[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      buf_data <= '0;
      buf_nb   <= '0;
      buf_last <= 1'b0;
      idx      <= '0;
      s_ready  <= 1'b0;
      en       <= 1'b0;
      sod      <= 1'b0;
      eop      <= 1'b0;
      char     <= '0;
      char_hot <= '0;
    end else begin
      st       <= st_d;
      buf_data <= buf_data_d;
      buf_nb   <= buf_nb_d;
      buf_last <= buf_last_d;
      idx      <= idx_d;
      s_ready  <= s_ready_d;
      en       <= en_d;
      sod      <= sod_d;
      eop      <= eop_d;
      char     <= char_d;
      char_hot <= hot_d;
    end
  end

endmodule

// File: tb/tb_payload_char_feeder.sv
module tb_payload_char_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  s_data;
  logic [7:0]   s_keep;
  logic         s_last, s_valid, pause;
  logic         s_ready, en, sod, eop;
  logic [7:0]   char;
  logic [255:0] char_hot;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int         sod_q[$], eop_q[$], en_q[$];
  logic [7:0] ch_q[$];

  payload_char_feeder #(.DATA_W(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_keep   (s_keep),
    .s_last   (s_last),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .pause    (pause),
    .char     (char),
    .char_hot (char_hot),
    .en       (en),
    .sod      (sod),
    .eop      (eop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus recorder plus per-cycle invariants, sampled mid-cycle
  always @(negedge clk) begin
    logic [255:0] hot_exp;
    hot_exp = '0;
    if (en) hot_exp[char] = 1'b1;
    chk("hot_decode", char_hot, hot_exp);
    chk("excl", 256'((32'(en) + 32'(sod) + 32'(eop)) <= 1), 256'd1);
    if (en)  begin en_q.push_back(cyc); ch_q.push_back(char); end
    if (sod) sod_q.push_back(cyc);
    if (eop) eop_q.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic clear_q();
    sod_q.delete(); eop_q.delete(); en_q.delete(); ch_q.delete();
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Offer a word; returns the cycle it was accepted in. s_valid stays high.
  task automatic offer(input logic [63:0] d, input logic [7:0] k, input logic l, output int t);
    s_data = d; s_keep = k; s_last = l; s_valid = 1'b1;
    for (int n = 0; n < 50 && !s_ready; n++) tick();
    t = cyc;
    chk("accept_ready", 256'(s_ready), 256'd1);
    tick();
  endtask

  task automatic chk_stream(input string tag, input logic [127:0] bytes, input int n);
    chk({tag, "_count"}, 256'(ch_q.size()), 256'(n));
    for (int i = 0; i < n; i++)
      chk({tag, "_char"}, 256'((i < ch_q.size()) ? ch_q[i] : 8'hxx), 256'(bytes[8*i +: 8]));
  endtask

  initial begin
    int t, t2;
    rst_n = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; s_valid = 1'b0; pause = 1'b0;
    #2;
    chk("rst_ready", 256'(s_ready), 256'd0);
    chk("rst_en",    256'(en),      256'd0);
    chk("rst_sod",   256'(sod),     256'd0);
    chk("rst_eop",   256'(eop),     256'd0);
    chk("rst_char",  256'(char),    256'd0);
    chk("rst_hot",   char_hot,      256'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: single word ".php?w=1"
    clear_q();
    offer(64'h313D773F7068702E, 8'hFF, 1'b1, t);
    s_valid = 1'b0;
    wait_cyc(t + 2);
    chk("t1_hot_first", char_hot, 256'b1 << 46);
    wait_cyc(t + 11);
    chk("t1_ready_back", 256'(s_ready), 256'd1);
    chk("t1_sod",   256'(qat(sod_q, 0)), 256'(t + 1));
    chk("t1_en0",   256'(qat(en_q, 0)),  256'(t + 2));
    chk("t1_en7",   256'(qat(en_q, 7)),  256'(t + 9));
    chk("t1_eop",   256'(qat(eop_q, 0)), 256'(t + 10));
    chk_stream("t1", 128'h313D773F7068702E, 8);

    // 2: two words, valid held, second keep=0x07
    clear_q();
    offer(64'h0706050403020100, 8'hFF, 1'b0, t);
    offer(64'h0000000000CCBBAA, 8'h07, 1'b1, t2);
    s_valid = 1'b0;
    chk("t2_reload_cyc", 256'(t2), 256'(t + 9));
    wait_cyc(t + 16);
    chk_stream("t2", 128'hCCBBAA0706050403020100, 11);
    chk("t2_en_first", 256'(qat(en_q, 0)),  256'(t + 2));
    chk("t2_en_last",  256'(qat(en_q, 10)), 256'(t + 12));
    chk("t2_eop",      256'(qat(eop_q, 0)), 256'(t + 13));

    // 3: pause for 3 cycles mid-word
    clear_q();
    offer(64'h1817161514131211, 8'hFF, 1'b1, t);
    s_valid = 1'b0;
    wait_cyc(t + 4);
    pause = 1'b1;
    wait_cyc(t + 6);
    chk("t3_paused_en",  256'(en), 256'd0);
    chk("t3_paused_hot", char_hot, 256'd0);
    wait_cyc(t + 7);
    pause = 1'b0;
    wait_cyc(t + 16);
    chk_stream("t3", 128'h1817161514131211, 8);
    chk("t3_en_before", 256'(qat(en_q, 2)), 256'(t + 4));
    chk("t3_en_after",  256'(qat(en_q, 3)), 256'(t + 8));
    chk("t3_eop",       256'(qat(eop_q, 0)), 256'(t + 13));

    // 4: zero-length packet, pause held throughout
    clear_q();
    pause = 1'b1;
    offer(64'h0, 8'h00, 1'b1, t);
    s_valid = 1'b0;
    wait_cyc(t + 5);
    pause = 1'b0;
    chk("t4_sod",   256'(qat(sod_q, 0)), 256'(t + 1));
    chk("t4_eop",   256'(qat(eop_q, 0)), 256'(t + 2));
    chk("t4_no_en", 256'(en_q.size()),   256'd0);

    // 5: 9-byte packet, second word late
    clear_q();
    offer(64'h2827262524232221, 8'hFF, 1'b0, t);
    s_valid = 1'b0;
    wait_cyc(t + 11);
    chk("t5_wait_en",    256'(en),      256'd0);
    chk("t5_wait_ready", 256'(s_ready), 256'd1);
    wait_cyc(t + 13);
    offer(64'h29, 8'h01, 1'b1, t2);
    s_valid = 1'b0;
    chk("t5_accept", 256'(t2), 256'(t + 13));
    wait_cyc(t + 18);
    chk_stream("t5", 128'h292827262524232221, 9);
    chk("t5_resume", 256'(qat(en_q, 8)),  256'(t + 14));
    chk("t5_eop",    256'(qat(eop_q, 0)), 256'(t + 15));

    // 6: reset during byte 3, then a normal packet
    clear_q();
    offer(64'h3837363534333231, 8'hFF, 1'b1, t);
    s_valid = 1'b0;
    wait_cyc(t + 4);
    chk("t6_byte3_en",   256'(en),   256'd1);
    chk("t6_byte3_char", 256'(char), 256'h33);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_en",    256'(en),      256'd0);
    chk("t6_rst_ready", 256'(s_ready), 256'd0);
    chk("t6_rst_hot",   char_hot,      256'd0);
    tick(); tick();
    rst_n = 1'b1;
    clear_q();
    wait_cyc(t + 16);
    chk("t6_no_eop", 256'(eop_q.size()), 256'd0);
    chk("t6_no_en",  256'(en_q.size()),  256'd0);
    offer(64'h41, 8'h01, 1'b1, t2);
    s_valid = 1'b0;
    wait_cyc(t2 + 5);
    chk("t6_sod",  256'(qat(sod_q, 0)), 256'(t2 + 1));
    chk("t6_en",   256'(qat(en_q, 0)),  256'(t2 + 2));
    chk("t6_eop",  256'(qat(eop_q, 0)), 256'(t2 + 3));
    chk_stream("t6", 128'h41, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
